// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Multi-cycle RV32I execute unit. Non-shift operations finish
//               in one cycle; shifts iterate one bit per cycle. Returns a
//               registered result plus branch-compare flags (lt/ltu) over a
//               valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_select,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             lt,
    output logic             ltu,
    output logic             busy
);

    // Operation encodings from the ALU control decoder.
    localparam logic [3:0] C_OP_ADD  = 4'b0000;
    localparam logic [3:0] C_OP_SUB  = 4'b0001;
    localparam logic [3:0] C_OP_SLL  = 4'b0010;
    localparam logic [3:0] C_OP_SRL  = 4'b0011;
    localparam logic [3:0] C_OP_SRA  = 4'b0100;
    localparam logic [3:0] C_OP_XOR  = 4'b0101;
    localparam logic [3:0] C_OP_OR   = 4'b0110;
    localparam logic [3:0] C_OP_AND  = 4'b0111;
    localparam logic [3:0] C_OP_SLT  = 4'b1000;
    localparam logic [3:0] C_OP_SLTU = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        sel_q, sel_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              zero_q, zero_d;
    logic              lt_q, lt_d;
    logic              ltu_q, ltu_d;

    logic              w_lt;
    logic              w_ltu;
    logic              w_is_shift;
    logic [4:0]        w_shamt;
    logic [WIDTH-1:0]  w_alu_res;
    logic [WIDTH-1:0]  w_acc_shifted;

    assign w_lt       = $signed(op_a) < $signed(op_b);
    assign w_ltu      = op_a < op_b;
    assign w_shamt    = op_b[4:0];
    assign w_is_shift = (alu_select == C_OP_SLL) || (alu_select == C_OP_SRL) ||
                        (alu_select == C_OP_SRA);

    // Single-cycle datapath for non-shift ops; illegal codes yield zero.
    always_comb begin
        w_alu_res = '0;
        case (alu_select)
            C_OP_ADD:  w_alu_res = op_a + op_b;
            C_OP_SUB:  w_alu_res = op_a - op_b;
            C_OP_XOR:  w_alu_res = op_a ^ op_b;
            C_OP_OR:   w_alu_res = op_a | op_b;
            C_OP_AND:  w_alu_res = op_a & op_b;
            C_OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, w_lt};
            C_OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, w_ltu};
            default:   w_alu_res = '0;
        endcase
    end

    // One-bit step of the iterative shifter, selected by the latched opcode.
    always_comb begin
        w_acc_shifted = acc_q;
        case (sel_q)
            C_OP_SLL: w_acc_shifted = {acc_q[WIDTH-2:0], 1'b0};
            C_OP_SRL: w_acc_shifted = {1'b0, acc_q[WIDTH-1:1]};
            C_OP_SRA: w_acc_shifted = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            default:  w_acc_shifted = acc_q;
        endcase
    end

    // Next-state and datapath register updates; everything holds by default.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        lt_d     = lt_q;
        ltu_d    = ltu_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sel_d = alu_select;
                    lt_d  = w_lt;
                    ltu_d = w_ltu;
                    if (w_is_shift && (w_shamt != 5'd0)) begin
                        acc_d   = op_a;
                        cnt_d   = w_shamt;
                        state_d = S_SHIFT;
                    end else if (w_is_shift) begin
                        // Zero shift amount passes the source straight through.
                        result_d = op_a;
                        zero_d   = (op_a == '0);
                        state_d  = S_DONE;
                    end else begin
                        result_d = w_alu_res;
                        zero_d   = (w_alu_res == '0);
                        state_d  = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                acc_d = w_acc_shifted;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    result_d = w_acc_shifted;
                    zero_d   = (w_acc_shifted == '0);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous abort on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            lt_q     <= 1'b0;
            ltu_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            lt_q     <= lt_d;
            ltu_q    <= ltu_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign lt        = lt_q;
    assign ltu       = ltu_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_alu
// Description : Self-checking bench for seq_alu with directed scenarios and
//               randomized operations against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_select;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        lt;
    logic        ltu;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_select (alu_select),
        .op_a       (op_a),
        .op_b       (op_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .lt         (lt),
        .ltu        (ltu),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: result straight from the operation's definition.
    function automatic logic [31:0] ref_result(input logic [3:0] sel,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (sel)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << sh;
            4'd3:    return a >> sh;
            4'd4:    return $unsigned($signed(a) >>> sh);
            4'd5:    return a ^ b;
            4'd6:    return a | b;
            4'd7:    return a & b;
            4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] sel, input logic [31:0] b);
        if ((sel == 4'd2 || sel == 4'd3 || sel == 4'd4) && b[4:0] != 5'd0)
            return 1 + int'(b[4:0]);
        return 1;
    endfunction

    // Drives one operation from IDLE and returns what the DUT produced.
    // Called at 1 time unit after a rising edge with the DUT idle.
    task automatic do_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic z, output logic l,
                         output logic lu, output int lat, output int busy_bad);
        alu_select = sel;
        op_a       = a;
        op_b       = b;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        alu_select = 4'($urandom);
        op_a       = $urandom;
        op_b       = $urandom;
        lat        = 1;
        busy_bad   = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready || !busy) busy_bad++;
            @(posedge clk);
            #1;
            lat++;
        end
        res = result;
        z   = zero;
        l   = lt;
        lu  = ltu;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        alu_select = 4'd0;
        op_a       = '0;
        op_b       = '0;
        #2;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
                     in_ready, out_valid, busy);
        end
        n_vec++;
        if (result !== 32'd0 || zero !== 1'b0 || lt !== 1'b0 || ltu !== 1'b0) begin
            n_err++;
            $display("FAIL reset_data: result=%h zero=%b lt=%b ltu=%b, want 0 0 0 0",
                     result, zero, lt, ltu);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add_overflow();
        logic [31:0] r; logic z, l, lu; int lat, bb;
        do_op(4'd0, 32'hFFFF_FFFF, 32'h1, r, z, l, lu, lat, bb);
        n_vec++;
        if (r !== 32'h0 || z !== 1'b1 || lat !== 1) begin
            n_err++;
            $display("FAIL add_overflow: result=%h zero=%b lat=%0d, want 00000000 1 1", r, z, lat);
        end
    endtask

    task automatic test_sub_flags();
        logic [31:0] r; logic z, l, lu; int lat, bb;
        do_op(4'd1, 32'd5, 32'd7, r, z, l, lu, lat, bb);
        n_vec++;
        if (r !== 32'hFFFF_FFFE || z !== 1'b0 || l !== 1'b1 || lu !== 1'b1) begin
            n_err++;
            $display("FAIL sub_5_7: result=%h zero=%b lt=%b ltu=%b, want fffffffe 0 1 1",
                     r, z, l, lu);
        end
        do_op(4'd1, 32'h8000_0000, 32'h1, r, z, l, lu, lat, bb);
        n_vec++;
        if (r !== 32'h7FFF_FFFF || l !== 1'b1 || lu !== 1'b0) begin
            n_err++;
            $display("FAIL sub_min_1: result=%h lt=%b ltu=%b, want 7fffffff 1 0", r, l, lu);
        end
    endtask

    task automatic test_max_shift();
        logic [31:0] r; logic z, l, lu; int lat, bb;
        do_op(4'd4, 32'h8000_0000, 32'd31, r, z, l, lu, lat, bb);
        n_vec++;
        if (r !== 32'hFFFF_FFFF || lat !== 32) begin
            n_err++;
            $display("FAIL sra_max: result=%h lat=%0d, want ffffffff 32", r, lat);
        end
        n_vec++;
        if (bb !== 0) begin
            n_err++;
            $display("FAIL sra_max_busy: %0d cycles with in_ready=1 or busy=0, want 0", bb);
        end
        do_op(4'd3, 32'h8000_0000, 32'd31, r, z, l, lu, lat, bb);
        n_vec++;
        if (r !== 32'h0000_0001 || lat !== 32 || z !== 1'b0) begin
            n_err++;
            $display("FAIL srl_max: result=%h lat=%0d zero=%b, want 00000001 32 0", r, lat, z);
        end
    endtask

    task automatic test_zero_shamt();
        logic [31:0] r; logic z, l, lu; int lat, bb;
        do_op(4'd2, 32'h1234_5678, 32'h0000_0020, r, z, l, lu, lat, bb);
        n_vec++;
        if (r !== 32'h1234_5678 || lat !== 1) begin
            n_err++;
            $display("FAIL sll_shamt0: result=%h lat=%0d, want 12345678 1", r, lat);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        alu_select = 4'd9;
        op_a       = 32'd1;
        op_b       = 32'd2;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b1 || result !== 32'd1) begin
            n_err++;
            $display("FAIL bp_first: out_valid=%b result=%h, want 1 00000001", out_valid, result);
        end
        // Competing request held high while the consumer stalls.
        alu_select = 4'd0;
        op_a       = 32'hAAAA_0000;
        op_b       = 32'h0000_5555;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || result !== 32'd1 || in_ready !== 1'b0 || zero !== 1'b0)
                bad++;
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL bp_hold: %0d unstable cycles, want 0 (result=%h out_valid=%b)",
                     bad, result, out_valid);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b, want 0 1 0",
                     out_valid, in_ready, busy);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_shift();
        logic [31:0] r; logic z, l, lu; int lat, bb;
        alu_select = 4'd2;
        op_a       = 32'hDEAD_BEEF;
        op_b       = 32'd20;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mid: out_valid=%b busy=%b in_ready=%b result=%h, want 0 0 1 0",
                     out_valid, busy, in_ready, result);
        end
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_op(4'd5, 32'hF0F0_F0F0, 32'hFFFF_0000, r, z, l, lu, lat, bb);
        n_vec++;
        if (r !== 32'h0F0F_F0F0 || lat !== 1) begin
            n_err++;
            $display("FAIL xor_after_reset: result=%h lat=%0d, want 0f0ff0f0 1", r, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] r; logic z, l, lu; int lat, bb;
        logic [3:0]  sel;
        logic [31:0] a, b, exp_r;
        int          exp_lat;
        for (int i = 0; i < 60; i++) begin
            sel = 4'($urandom_range(0, 15));
            a   = $urandom;
            b   = $urandom;
            if (i % 4 == 0) a = a & 32'h0000_000F;
            if (i % 5 == 0) b = a;
            exp_r   = ref_result(sel, a, b);
            exp_lat = ref_latency(sel, b);
            do_op(sel, a, b, r, z, l, lu, lat, bb);
            n_vec++;
            if (r !== exp_r || z !== (exp_r == 32'd0)) begin
                n_err++;
                $display("FAIL rand_result sel=%0d a=%h b=%h: result=%h zero=%b, want %h %b",
                         sel, a, b, r, z, exp_r, (exp_r == 32'd0));
            end
            n_vec++;
            if (l !== ($signed(a) < $signed(b)) || lu !== (a < b)) begin
                n_err++;
                $display("FAIL rand_flags sel=%0d a=%h b=%h: lt=%b ltu=%b, want %b %b",
                         sel, a, b, l, lu, ($signed(a) < $signed(b)), (a < b));
            end
            n_vec++;
            if (lat !== exp_lat || bb !== 0) begin
                n_err++;
                $display("FAIL rand_latency sel=%0d b=%h: lat=%0d busy_bad=%0d, want %0d 0",
                         sel, b, lat, bb, exp_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_flags();
        test_max_shift();
        test_zero_shamt();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
